ibex_multdiv_slow: RTL
======================

// Module: ibex_multdiv_slow
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, beside ibex_alu.
//  Decode drives it with the same register operands it gives the ALU. The EX result mux selects io_result_o when io_valid_o=1.
//  Radix-2: one partial product, or one restoring-division step, per cycle.
//  Has its own 33-bit adder; it does not share the ALU adder.
// PARAMETERS
//  XLEN     32  operand/result width (only 32 supported)
//  CNT_W    5   iteration counter width (log2 XLEN)
// PORTS
//  clock             in   1   core clock, all state on rising edge
//  reset             in   1   asynchronous, active-low (0 = reset)
//  io_en_i           in   1   request; sampled only while io_ready_o=1
//  io_kill_i         in   1   abort current op (flush/exception)
//  io_operator_i     in   2   MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3
//  io_signed_mode_i  in   2   bit0: op_a signed, bit1: op_b signed
//  io_op_a_i         in   32  rs1 (multiplicand / dividend)
//  io_op_b_i         in   32  rs2 (multiplier / divisor)
//  io_ready_o        out  1   1 in IDLE only
//  io_valid_o        out  1   result valid, single-cycle pulse
//  io_result_o       out  32  result, held until next accept
// BEHAVIOUR
//  Reset values: state=IDLE, io_ready_o=1, io_valid_o=0, io_result_o=0, counter=0.
//  FSM IDLE -> CALC -> FINISH -> IDLE.
//   IDLE: if en_i & ~kill_i, the unit accepts the request:
//    - latch operator and |a|, |b| (magnitude when signed and MSB=1)
//    - latch res_neg, div_by_zero, counter=31; go to CALC
//    - en_i while not IDLE is ignored; no queueing
//   CALC: one step per cycle for 32 cycles (counter 31..0), then FINISH.
//    - MUL: 64-bit acc; if mb[i], add ma<<i via shift-add
//    - DIV/REM: restoring; rem=(rem<<1)|a[msb]; if rem>=|b|: rem-=|b|, q bit=1
//   FINISH: io_valid_o=1 for exactly this cycle; io_result_o registered on entry:
//    - MULL: prod[31:0]; MULH: prod[63:32]
//    - prod is negated as 64 bits when res_neg
//    - DIV: q, negated if res_neg; REM: rem, negated if a signed & a<0
//  Latency: accept at cycle T -> io_valid_o at T+33; next accept possible at T+34.
//  res_neg: MUL = (sa&a31)^(sb&b31); DIV = (sa&a31)^(sb&b31).
//  Boundary cases:
//   - div by zero (b==0): DIV/DIVU -> 32'hFFFFFFFF, REM/REMU -> a (unmodified); full latency kept.
//   - signed overflow 0x80000000 / -1: DIV -> 0x80000000, REM -> 0; falls out of magnitude math with 32-bit wrap.
//   - kill_i in CALC/FINISH -> IDLE next cycle; io_valid_o forced 0 combinationally that cycle.
//   - io_result_o is not updated on kill.
//   - kill_i & en_i together in IDLE -> not accepted.
//   - reset asserted mid-op -> immediate IDLE, outputs to reset values, no valid pulse.
//  Operands and operator may change after accept without effect.
// STRUCTURE
//  ibex_pkg: md_op_e (MD_OP_MULL/MULH/DIV/REM); md_fsm_e (IDLE/CALC/FINISH); XLEN.
//  Single module, no sub-module; datapath is one 33-bit add/sub shared by MUL and DIV steps.
// TESTING
//  1 MULL, mode 00, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; valid exactly T+33, one cycle.
//  2 MULH, mode 11, a=b=0x80000000 -> result 0x40000000.
//    MULH, mode 01, a=b=0xFFFFFFFF -> result 0xFFFFFFFF.
//  3 DIV, mode 11, a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD.
//    REM, same operands -> 0xFFFFFFFF.
//    DIVU, a=100, b=7 -> 14.
//  4 Div by zero: DIVU, a=5, b=0 -> 0xFFFFFFFF.
//    REM, mode 11, a=0xFFFFFFFB, b=0 -> 0xFFFFFFFB.
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5 Kill/handshake:
//    - kill_i at T+10 -> no valid; ready_o=1 at T+11; new op accepted T+11 gives correct result.
//    - en_i pulses while busy are ignored.
//    - kill in FINISH -> valid stays 0.
//  6 Reset: reset=0 at T+20 (async, mid-clock) -> ready_o=1, valid_o=0, result_o=0 immediately.
//    Release, then MULL 3*4 -> 12.

Source files
------------

// File: rtl/ibex_multdiv_slow_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package ibex_multdiv_slow_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } md_fsm_e;

   // Magnitude of an operand; only negated when it is treated as signed.
   function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] v, input logic sgn);
      if (sgn && v[XLEN-1]) begin
         md_mag = ~v + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         md_mag = v;
      end
   endfunction

endpackage

// File: rtl/ibex_multdiv_slow.sv
// Radix-2 iterative multiply/divide: one shift-add or one restoring step per cycle,
// built around a single 33-bit adder shared by both operations.
module ibex_multdiv_slow
   import ibex_multdiv_slow_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            io_en_i,
   input  logic            io_kill_i,
   input  logic [1:0]      io_operator_i,
   input  logic [1:0]      io_signed_mode_i,
   input  logic [XLEN-1:0] io_op_a_i,
   input  logic [XLEN-1:0] io_op_b_i,
   output logic            io_ready_o,
   output logic            io_valid_o,
   output logic [XLEN-1:0] io_result_o
);

   md_fsm_e            state_r;
   md_op_e             op_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [XLEN-1:0]    opnd_r;
   logic [XLEN-1:0]    hi_r;
   logic [XLEN-1:0]    lo_r;
   logic               res_neg_r;
   logic               a_neg_r;
   logic               dbz_r;
   logic               ready_r;
   logic               valid_r;
   logic [XLEN-1:0]    result_r;

   md_op_e             op_in_s;
   logic               req_mul_s;
   logic [XLEN-1:0]    a_mag_s;
   logic [XLEN-1:0]    b_mag_s;
   logic               is_mul_s;
   logic [XLEN:0]      add_a_s;
   logic [XLEN:0]      add_b_s;
   logic [XLEN:0]      sum_s;
   logic [XLEN-1:0]    hi_nxt_s;
   logic [XLEN-1:0]    lo_nxt_s;
   logic [2*XLEN-1:0]  prod_neg_s;
   logic [XLEN-1:0]    res_s;

   // Request decode: operand magnitudes and which datapath the request uses.
   always_comb begin
      op_in_s   = md_op_e'(io_operator_i);
      a_mag_s   = md_mag(io_op_a_i, io_signed_mode_i[0]);
      b_mag_s   = md_mag(io_op_b_i, io_signed_mode_i[1]);
      req_mul_s = (op_in_s == MD_OP_MULL) || (op_in_s == MD_OP_MULH);
   end

   // Shared adder. MUL: hi += lo[0] ? opnd : 0, then shift {sum, lo} right.
   // DIV: {hi, lo[msb]} - opnd; bit XLEN of the difference is the borrow.
   always_comb begin
      is_mul_s = (op_r == MD_OP_MULL) || (op_r == MD_OP_MULH);
      add_a_s  = {(XLEN+1){1'b0}};
      add_b_s  = {(XLEN+1){1'b0}};
      if (is_mul_s) begin
         add_a_s = {1'b0, hi_r};
         if (lo_r[0]) begin
            add_b_s = {1'b0, opnd_r};
         end else begin
            add_b_s = {(XLEN+1){1'b0}};
         end
      end else begin
         add_a_s = {hi_r, lo_r[XLEN-1]};
         add_b_s = ~{1'b0, opnd_r};
      end
      sum_s = add_a_s + add_b_s + {{XLEN{1'b0}}, ~is_mul_s};

      if (is_mul_s) begin
         hi_nxt_s = sum_s[XLEN:1];
         lo_nxt_s = {sum_s[0], lo_r[XLEN-1:1]};
      end else if (sum_s[XLEN]) begin
         hi_nxt_s = add_a_s[XLEN-1:0];
         lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
      end else begin
         hi_nxt_s = sum_s[XLEN-1:0];
         lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
      end
   end

   // Sign fix-up of the final step, registered on entry to FINISH.
   always_comb begin
      if (res_neg_r) begin
         prod_neg_s = ~{hi_nxt_s, lo_nxt_s} + {{(2*XLEN-1){1'b0}}, 1'b1};
      end else begin
         prod_neg_s = {hi_nxt_s, lo_nxt_s};
      end
      case (op_r)
         MD_OP_MULL: res_s = prod_neg_s[XLEN-1:0];
         MD_OP_MULH: res_s = prod_neg_s[2*XLEN-1:XLEN];
         MD_OP_DIV: begin
            if (dbz_r) begin
               res_s = {XLEN{1'b1}};
            end else if (res_neg_r) begin
               res_s = ~lo_nxt_s + {{(XLEN-1){1'b0}}, 1'b1};
            end else begin
               res_s = lo_nxt_s;
            end
         end
         MD_OP_REM: begin
            if (a_neg_r) begin
               res_s = ~hi_nxt_s + {{(XLEN-1){1'b0}}, 1'b1};
            end else begin
               res_s = hi_nxt_s;
            end
         end
         default: res_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         op_r      <= MD_OP_MULL;
         cnt_r     <= {CNT_W{1'b0}};
         opnd_r    <= {XLEN{1'b0}};
         hi_r      <= {XLEN{1'b0}};
         lo_r      <= {XLEN{1'b0}};
         res_neg_r <= 1'b0;
         a_neg_r   <= 1'b0;
         dbz_r     <= 1'b0;
         ready_r   <= 1'b1;
         valid_r   <= 1'b0;
         result_r  <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               valid_r <= 1'b0;
               if (io_en_i && !io_kill_i) begin
                  state_r   <= CALC;
                  ready_r   <= 1'b0;
                  op_r      <= op_in_s;
                  cnt_r     <= {CNT_W{1'b1}};
                  hi_r      <= {XLEN{1'b0}};
                  opnd_r    <= req_mul_s ? a_mag_s : b_mag_s;
                  lo_r      <= req_mul_s ? b_mag_s : a_mag_s;
                  a_neg_r   <= io_signed_mode_i[0] & io_op_a_i[XLEN-1];
                  res_neg_r <= (io_signed_mode_i[0] & io_op_a_i[XLEN-1]) ^
                               (io_signed_mode_i[1] & io_op_b_i[XLEN-1]);
                  dbz_r     <= (io_op_b_i == {XLEN{1'b0}});
               end else begin
                  ready_r <= 1'b1;
               end
            end
            CALC: begin
               if (io_kill_i) begin
                  state_r <= IDLE;
                  ready_r <= 1'b1;
               end else begin
                  hi_r <= hi_nxt_s;
                  lo_r <= lo_nxt_s;
                  if (cnt_r == {CNT_W{1'b0}}) begin
                     state_r  <= FINISH;
                     valid_r  <= 1'b1;
                     result_r <= res_s;
                  end else begin
                     cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            FINISH: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign io_ready_o  = ready_r;
   assign io_valid_o  = valid_r & ~io_kill_i;
   assign io_result_o = result_r;

endmodule
